// File: rtl/riscv_cache_types_pkg.sv
// Shared L1 cache types: request/response bundles and line fill buffer types.
// Imported by the cache controller and the line fill buffer.
package riscv_cache_types_pkg;

  localparam int unsigned DEFAULT_CACHE_LINE_SIZE = 32;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned CACHE_ID_W = 4;
  localparam int unsigned LFB_WORDS = DEFAULT_CACHE_LINE_SIZE / 4;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [CACHE_ID_W-1:0] id;
    logic                  we;
    logic [31:0]           wdata;
  } cache_req_t;

  typedef struct packed {
    logic [31:0]           rdata;
    logic [CACHE_ID_W-1:0] id;
    logic                  error;
  } cache_rsp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } lfb_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]   addr;
    logic [LFB_WORDS*32-1:0] data;
    logic                    error;
  } lfb_fill_t;

endpackage

// File: rtl/riscv_cache_line_fill_buffer.sv
// Miss-side line fill buffer: one wrapping line read per miss,
// critical word forwarded early, full line handed back to the controller.
module riscv_cache_line_fill_buffer
  import riscv_cache_types_pkg::*;
#(
  parameter int unsigned LINE_BYTES = DEFAULT_CACHE_LINE_SIZE,
  parameter int unsigned ADDR_W     = ADDR_WIDTH,
  parameter int unsigned ID_W       = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    miss_valid_i,
  output logic                    miss_ready_o,
  input  logic [ADDR_W-1:0]       miss_addr_i,
  input  logic [ID_W-1:0]         miss_id_i,
  output logic                    mem_req_valid_o,
  input  logic                    mem_req_ready_i,
  output logic [ADDR_W-1:0]       mem_req_addr_o,
  input  logic                    mem_rsp_valid_i,
  output logic                    mem_rsp_ready_o,
  input  logic [31:0]             mem_rsp_data_i,
  input  logic                    mem_rsp_error_i,
  output logic                    crit_valid_o,
  output logic [31:0]             crit_data_o,
  output logic [ID_W-1:0]         crit_id_o,
  output logic                    crit_error_o,
  output logic                    fill_valid_o,
  input  logic                    fill_ready_i,
  output logic [ADDR_W-1:0]       fill_addr_o,
  output logic [LINE_BYTES*8-1:0] fill_data_o,
  output logic                    fill_error_o
);

  localparam int unsigned WORDS = LINE_BYTES / 4;
  localparam int unsigned OFF   = $clog2(LINE_BYTES);
  localparam int unsigned IDXW  = OFF - 2;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);
  localparam logic [IDXW-1:0]   LAST_CNT  = IDXW'(WORDS - 1);

  lfb_state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [IDXW-1:0] widx_q, widx_d;
  logic [IDXW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic [WORDS-1:0][31:0] line_q, line_d;
  logic crit_valid_q, crit_valid_d;
  logic [31:0] crit_data_q, crit_data_d;
  logic crit_err_q, crit_err_d;
  logic miss_ready_q, miss_ready_d;
  logic req_valid_q, req_valid_d;
  logic rsp_ready_q, rsp_ready_d;
  logic fill_valid_q, fill_valid_d;

  // Next-state, datapath and registered handshake outputs.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    id_d        = id_q;
    widx_d      = widx_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    line_d      = line_q;
    crit_valid_d = 1'b0;
    crit_data_d = crit_data_q;
    crit_err_d  = crit_err_q;
    unique case (state_q)
      IDLE: begin
        if (miss_valid_i && miss_ready_q) begin
          addr_d  = miss_addr_i;
          id_d    = miss_id_i;
          widx_d  = miss_addr_i[OFF-1:2];
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (req_valid_q && mem_req_ready_i) state_d = FILL;
      end
      FILL: begin
        if (mem_rsp_valid_i && rsp_ready_q) begin
          line_d[widx_q] = mem_rsp_data_i;
          widx_d = widx_q + IDXW'(1);
          cnt_d  = cnt_q + IDXW'(1);
          err_d  = err_q | mem_rsp_error_i;
          if (cnt_q == '0) begin
            crit_valid_d = 1'b1;
            crit_data_d  = mem_rsp_data_i;
            crit_err_d   = mem_rsp_error_i;
          end
          if (cnt_q == LAST_CNT) state_d = DONE;
        end
      end
      DONE: begin
        if (fill_valid_q && fill_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    miss_ready_d = (state_d == IDLE);
    req_valid_d  = (state_d == REQ);
    rsp_ready_d  = (state_d == FILL);
    fill_valid_d = (state_d == DONE);
  end

  // All state and outputs cleared on reset; a partial line is dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      id_q         <= '0;
      widx_q       <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      line_q       <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
      crit_err_q   <= 1'b0;
      miss_ready_q <= 1'b0;
      req_valid_q  <= 1'b0;
      rsp_ready_q  <= 1'b0;
      fill_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      id_q         <= id_d;
      widx_q       <= widx_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      line_q       <= line_d;
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
      crit_err_q   <= crit_err_d;
      miss_ready_q <= miss_ready_d;
      req_valid_q  <= req_valid_d;
      rsp_ready_q  <= rsp_ready_d;
      fill_valid_q <= fill_valid_d;
    end
  end

  assign miss_ready_o    = miss_ready_q;
  assign mem_req_valid_o = req_valid_q;
  assign mem_req_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_rsp_ready_o = rsp_ready_q;
  assign crit_valid_o    = crit_valid_q;
  assign crit_data_o     = crit_data_q;
  assign crit_id_o       = id_q;
  assign crit_error_o    = crit_err_q;
  assign fill_valid_o    = fill_valid_q;
  assign fill_addr_o     = addr_q & LINE_MASK;
  assign fill_data_o     = line_q;
  assign fill_error_o    = err_q;

endmodule

// File: tb/tb_riscv_cache_line_fill_buffer.sv
// Directed bench for the line fill buffer: aligned, wrapping, error,
// backpressure, ignore and mid-fill reset scenarios.
module tb_riscv_cache_line_fill_buffer;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         miss_valid_i;
  logic         miss_ready_o;
  logic [31:0]  miss_addr_i;
  logic [3:0]   miss_id_i;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i;
  logic [31:0]  mem_req_addr_o;
  logic         mem_rsp_valid_i;
  logic         mem_rsp_ready_o;
  logic [31:0]  mem_rsp_data_i;
  logic         mem_rsp_error_i;
  logic         crit_valid_o;
  logic [31:0]  crit_data_o;
  logic [3:0]   crit_id_o;
  logic         crit_error_o;
  logic         fill_valid_o;
  logic         fill_ready_i;
  logic [31:0]  fill_addr_o;
  logic [255:0] fill_data_o;
  logic         fill_error_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int crit_cnt = 0;
  int crit_cyc = 0;
  int fill_cnt = 0;
  logic [31:0] crit_d;
  logic [3:0] crit_i;
  logic crit_e;

  riscv_cache_line_fill_buffer dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
    .miss_addr_i(miss_addr_i), .miss_id_i(miss_id_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
    .mem_rsp_data_i(mem_rsp_data_i), .mem_rsp_error_i(mem_rsp_error_i),
    .crit_valid_o(crit_valid_o), .crit_data_o(crit_data_o),
    .crit_id_o(crit_id_o), .crit_error_o(crit_error_o),
    .fill_valid_o(fill_valid_o), .fill_ready_i(fill_ready_i),
    .fill_addr_o(fill_addr_o), .fill_data_o(fill_data_o),
    .fill_error_o(fill_error_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (crit_valid_o) begin
      crit_cnt = crit_cnt + 1;
      crit_cyc = cyc;
      crit_d = crit_data_o;
      crit_i = crit_id_o;
      crit_e = crit_error_o;
    end
    if (fill_valid_o) fill_cnt = fill_cnt + 1;
  end

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_miss(
    input string tg, input logic [31:0] addr, input logic [3:0] id,
    input logic [7:0] base, input logic [7:0] emask,
    input int req_stall, input int gap, input int fill_stall,
    input logic [31:0] exp_req, input logic [31:0] exp_fa,
    input logic [255:0] exp_line, input logic exp_ferr,
    input logic exp_cerr);
    int t0, b0, c0;
    c0 = crit_cnt;
    chk({tg, "_mrdy"}, miss_ready_o, 1);
    miss_valid_i = 1; miss_addr_i = addr; miss_id_i = id;
    t0 = cyc;
    step();
    miss_valid_i = 0;
    chk({tg, "_reqv"}, mem_req_valid_o, 1);
    chk({tg, "_reqa"}, mem_req_addr_o, exp_req);
    chk({tg, "_mrdy0"}, miss_ready_o, 0);
    for (int k = 0; k < req_stall; k++) begin
      step();
      chk({tg, "_reqv_hold"}, mem_req_valid_o, 1);
      chk({tg, "_reqa_hold"}, mem_req_addr_o, exp_req);
    end
    mem_req_ready_i = 1;
    step();
    mem_req_ready_i = 0;
    chk({tg, "_reqv_off"}, mem_req_valid_o, 0);
    if (fill_stall == 0) fill_ready_i = 1;
    b0 = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0)
        for (int g = 0; g < gap; g++) begin
          step();
          chk({tg, "_gap_nofill"}, fill_valid_o, 0);
        end
      chk({tg, "_rsprdy"}, mem_rsp_ready_o, 1);
      mem_rsp_valid_i = 1;
      mem_rsp_data_i = {24'h0, base + 8'(i)};
      mem_rsp_error_i = emask[i];
      if (i == 0) b0 = cyc;
      step();
      mem_rsp_valid_i = 0;
      mem_rsp_error_i = 0;
    end
    chk({tg, "_fillv"}, fill_valid_o, 1);
    chk({tg, "_rsprdy0"}, mem_rsp_ready_o, 0);
    if (req_stall == 0 && gap == 0) begin
      chk({tg, "_fill_lat"}, cyc - t0, 10);
      chk({tg, "_crit_lat"}, crit_cyc - t0, 3);
    end
    chk({tg, "_filla"}, fill_addr_o, exp_fa);
    chk({tg, "_filld"}, fill_data_o, exp_line);
    chk({tg, "_fille"}, fill_error_o, exp_ferr);
    for (int k = 0; k < fill_stall; k++) begin
      step();
      chk({tg, "_fillv_hold"}, fill_valid_o, 1);
      chk({tg, "_filld_hold"}, fill_data_o, exp_line);
      chk({tg, "_filla_hold"}, fill_addr_o, exp_fa);
      chk({tg, "_mrdy_hold"}, miss_ready_o, 0);
    end
    fill_ready_i = 1;
    step();
    fill_ready_i = 0;
    chk({tg, "_fillv_off"}, fill_valid_o, 0);
    chk({tg, "_mrdy_back"}, miss_ready_o, 1);
    chk({tg, "_crit_cnt"}, crit_cnt - c0, 1);
    chk({tg, "_crit_d"}, crit_d, {24'h0, base});
    chk({tg, "_crit_id"}, crit_i, id);
    chk({tg, "_crit_e"}, crit_e, exp_cerr);
    chk({tg, "_crit_beat"}, crit_cyc - b0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc;
    rst_ni = 0;
    miss_valid_i = 0; miss_addr_i = 0; miss_id_i = 0;
    mem_req_ready_i = 0; mem_rsp_valid_i = 0;
    mem_rsp_data_i = 0; mem_rsp_error_i = 0; fill_ready_i = 0;
    step();
    step();
    chk("rst_mrdy", miss_ready_o, 0);
    chk("rst_reqv", mem_req_valid_o, 0);
    chk("rst_rsprdy", mem_rsp_ready_o, 0);
    chk("rst_crit", crit_valid_o, 0);
    chk("rst_fillv", fill_valid_o, 0);
    chk("rst_filld", fill_data_o, 0);
    chk("rst_filla", fill_addr_o, 0);
    rst_ni = 1;
    step();
    chk("post_rst_mrdy", miss_ready_o, 1);

    mem_rsp_valid_i = 1; mem_rsp_data_i = 32'hDEAD;
    chk("idle_rsprdy", mem_rsp_ready_o, 0);
    step();
    mem_rsp_valid_i = 0;
    chk("idle_stay", miss_ready_o, 1);
    chk("idle_nocrit", crit_cnt, 0);

    run_miss("aligned", 32'h0000_1000, 4'd3, 8'hA0, 8'h00, 0, 0, 1,
      32'h1000, 32'h1000,
      256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0,
      1'b0, 1'b0);

    run_miss("wrap", 32'h0000_2014, 4'd6, 8'hB0, 8'h00, 0, 0, 0,
      32'h2014, 32'h2000,
      256'h000000B2_000000B1_000000B0_000000B7_000000B6_000000B5_000000B4_000000B3,
      1'b0, 1'b0);

    run_miss("err", 32'h0000_1000, 4'd3, 8'hA0, 8'h10, 0, 0, 1,
      32'h1000, 32'h1000,
      256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0,
      1'b1, 1'b0);

    run_miss("bp", 32'h0000_300A, 4'd9, 8'hC0, 8'h00, 3, 2, 5,
      32'h3008, 32'h3000,
      256'h000000C5_000000C4_000000C3_000000C2_000000C1_000000C0_000000C7_000000C6,
      1'b0, 1'b0);

    miss_valid_i = 1; miss_addr_i = 32'h1000; miss_id_i = 4'd5;
    step();
    miss_valid_i = 0;
    mem_req_ready_i = 1;
    step();
    mem_req_ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      miss_valid_i = 1; miss_addr_i = 32'h5000; miss_id_i = 4'd7;
      chk("ign_mrdy", miss_ready_o, 0);
      mem_rsp_valid_i = 1;
      mem_rsp_data_i = 32'hD0 + 32'(i);
      step();
      mem_rsp_valid_i = 0;
    end
    miss_valid_i = 0;
    fc = fill_cnt;
    #2;
    rst_ni = 0;
    #1;
    chk("mrst_mrdy", miss_ready_o, 0);
    chk("mrst_reqv", mem_req_valid_o, 0);
    chk("mrst_rsprdy", mem_rsp_ready_o, 0);
    chk("mrst_crit", crit_valid_o, 0);
    chk("mrst_critd", crit_data_o, 0);
    chk("mrst_fillv", fill_valid_o, 0);
    chk("mrst_filld", fill_data_o, 0);
    chk("mrst_fille", fill_error_o, 0);
    step();
    step();
    rst_ni = 1;
    step();
    chk("mrst_nofill", fill_cnt - fc, 0);
    run_miss("after_rst", 32'h0000_1000, 4'd3, 8'hA0, 8'h00, 0, 0, 1,
      32'h1000, 32'h1000,
      256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0,
      1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_cache_line_fill_buffer.md
Name: riscv_cache_line_fill_buffer

Overview:
- Miss-side line fill buffer between the L1 cache controller and the memory interface.
- Accepts one miss (address plus id) from the controller's CACHE_MISS state and issues a single wrapping line read to memory.
- Assembles the returning beats into a full line, critical word first, and forwards the critical word early.
- Hands the completed line to the controller's CACHE_FILL state.

Parameters:
- LINE_BYTES, DEFAULT_CACHE_LINE_SIZE (32): line size in bytes; must be a power of 2 and at least 8.
- ADDR_W, ADDR_WIDTH (32): address width.
- ID_W, 4: request id width; matches the id field of cache_req_t and cache_rsp_t.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active-low.
- miss_valid_i  in  1  miss request valid.
- miss_ready_o  out  1  buffer can accept a miss.
- miss_addr_i  in  ADDR_W  byte address of the missing access.
- miss_id_i  in  ID_W  id of the missing access.
- mem_req_valid_o  out  1  line read request valid.
- mem_req_ready_i  in  1  memory accepts the request.
- mem_req_addr_o  out  ADDR_W  word-aligned critical-word address; memory returns beats in wrap order.
- mem_rsp_valid_i  in  1  beat valid.
- mem_rsp_ready_o  out  1  buffer accepts a beat.
- mem_rsp_data_i  in  32  beat data.
- mem_rsp_error_i  in  1  beat error.
- crit_valid_o  out  1  one-cycle critical-word pulse; no backpressure.
- crit_data_o  out  32  critical word.
- crit_id_o  out  ID_W  id of the miss.
- crit_error_o  out  1  error on the critical beat.
- fill_valid_o  out  1  assembled line valid.
- fill_ready_i  in  1  controller accepts the line.
- fill_addr_o  out  ADDR_W  line-aligned address.
- fill_data_o  out  LINE_BYTES*8  line data; word w occupies bits [32w+31:32w].
- fill_error_o  out  1  sticky OR of all beat errors.

Behaviour:
- Derived values: WORDS = LINE_BYTES/4; OFF = log2(LINE_BYTES); word index = addr[OFF-1:2].
- States: IDLE, REQ, FILL, DONE.
- Reset (async, rst_ni=0): state IDLE. All valid outputs 0, mem_rsp_ready_o 0. Data, address, id and error registers 0. miss_ready_o goes to 1 once reset deasserts.
- IDLE:
  - miss_ready_o=1.
  - On miss_valid_i, capture addr, id and start index ws = word index of miss_addr_i.
  - Set widx=ws, beat counter cnt=0, error accumulator=0, then go to REQ.
- REQ:
  - mem_req_valid_o=1 starting the cycle after the miss handshake.
  - mem_req_addr_o = {captured_addr[ADDR_W-1:2], 2'b00}, held stable until mem_req_ready_i.
  - On handshake, go to FILL.
- FILL:
  - mem_rsp_ready_o=1.
  - Each accepted beat writes line word widx; widx = (widx+1) mod WORDS (wrap from WORDS-1 to 0); cnt += 1; error |= mem_rsp_error_i.
  - On the beat where cnt==0: crit_valid_o=1 on the next cycle for exactly one cycle, with crit_data_o/crit_error_o equal to that beat and crit_id_o = captured id.
  - On the beat where cnt==WORDS-1, go to DONE.
  - Error beats are counted and stored like normal beats; a fill is never aborted early.
- DONE:
  - fill_valid_o=1 with fill_addr_o = captured_addr with the low OFF bits zeroed.
  - fill_data_o and fill_error_o are stable until fill_ready_i.
  - On handshake, go to IDLE. miss_ready_o rises the cycle after the handshake; there is no same-cycle re-accept.
- Latency:
  - Miss handshake at cycle t gives mem_req_valid_o at t+1.
  - Critical word appears one cycle after its beat.
  - fill_valid_o rises one cycle after the last beat.
  - With zero memory latency: t+1 request, t+2..t+1+WORDS beats, fill_valid_o at t+2+WORDS.
- Boundary rules:
  - miss_valid_i outside IDLE is ignored (ready=0).
  - mem_rsp_valid_i outside FILL is ignored (ready=0) and no state changes.
  - fill_ready_i held high before DONE completes the handshake in the first DONE cycle.
  - Stalls between beats (valid low) hold all state.
  - Reset mid-REQ/FILL/DONE discards the line with no crit or fill output. The memory side must be reset with the same rst_ni.
  - WORDS=2 degenerates correctly: the critical word is the first beat and the wrap is a single increment.

Decomposition:
- riscv_cache_types_pkg gains:
  - lfb_state_e (2-bit enum IDLE/REQ/FILL/DONE).
  - LFB_WORDS = DEFAULT_CACHE_LINE_SIZE/4.
  - A packed lfb_fill_t {addr, data, error} for the fill output bundle.
- No sub-module: a single module with one FSM, an index counter and a word-register array.

Test Plan:
- Aligned miss: LINE_BYTES=32, addr 0x0000_1000, id 3; memory returns 0xA0..0xA7 with zero wait.
  - mem_req_addr 0x1000.
  - crit 0xA0, id 3, at cycle t+3.
  - fill_addr 0x1000, word w = 0xA0+w, fill_valid at t+10, error 0.
- Wrap miss: addr 0x0000_2014 (word 5); beats B0..B7.
  - mem_req_addr 0x2014.
  - crit=B0.
  - line word5=B0, 6=B1, 7=B2, 0=B3 … 4=B7; fill_addr 0x2000.
- Error beat: as scenario 1, with mem_rsp_error_i set on beat 4 only.
  - crit_error_o=0, fill_error_o=1.
  - All 8 beats still consumed.
- Backpressure: mem_req_ready_i low for 3 cycles, gaps between beats, fill_ready_i low for 5 cycles.
  - Request address and fill outputs held stable.
  - Exactly one crit pulse.
  - miss_ready_o rises the cycle after the fill handshake.
- Ignore and reset: a second miss_valid_i during FILL is not accepted; rst_ni pulsed low mid-FILL (after beat 3).
  - All outputs 0 immediately.
  - No fill_valid_o.
  - A new miss after reset proceeds normally.
